// File: rtl/snn_pkg.sv
// Shared SNN definitions: neuron index width, default queue depth and the
// spike encoder FSM state encoding.
package snn_pkg;

  localparam int NEURON_ID_W         = 8;
  localparam int QUEUE_DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } spike_enc_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder over the pending fire mask.
module prio_enc_lsb
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 256
) (
  input  logic [NUM_NEURONS-1:0] i_vec,
  output logic [NEURON_ID_W-1:0] o_idx,
  output logic                   o_found
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = NEURON_ID_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Spike encoder: turns a sampled fire vector into ascending neuron indices for
// the spike event queue, throttled by a mirrored queue occupancy count.
// Optional lifetime insert counter enabled by defining SPIKE_ENCODER_STATS_EN.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               step_i,
  input  logic [NUM_NEURONS-1:0]             spikes_i,
  input  logic                               queue_read_i,
  output logic                               insert_o,
  output logic [NEURON_ID_W-1:0]             data_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [$clog2(NUM_NEURONS+1)-1:0]   count_o,
  output logic [31:0]                        stat_total_o
);

  localparam int OCC_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);

  spike_enc_state_t r_state, w_state_nxt;

  logic [NUM_NEURONS-1:0] r_mask;
  logic [CNT_W-1:0]       r_step_cnt;
  logic [CNT_W-1:0]       r_count;
  logic                   r_insert;
  logic [NEURON_ID_W-1:0] r_data;
  logic [OCC_W-1:0]       r_occ;

  logic [NEURON_ID_W-1:0] w_idx;
  logic                   w_found;
  logic                   w_rd_eff;
  logic [OCC_W-1:0]       w_occ_next;
  logic                   w_room;
  logic                   w_accept;
  logic                   w_issue;
  logic                   w_load_count;

  prio_enc_lsb #(
    .NUM_NEURONS(NUM_NEURONS)
  ) u_prio (
    .i_vec  (r_mask),
    .o_idx  (w_idx),
    .o_found(w_found)
  );

  // Occupancy the queue will hold after this edge; the registered insert
  // already on the bus counts, so issuing only when this is below depth can
  // never overwrite an unread entry.
  assign w_rd_eff   = queue_read_i && (r_occ != '0);
  assign w_occ_next = r_occ + OCC_W'(r_insert) - OCC_W'(w_rd_eff);
  assign w_room     = (w_occ_next < OCC_W'(QUEUE_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (step_i)   w_state_nxt = ST_SCAN;
      ST_SCAN: if (!w_found) w_state_nxt = ST_DONE;
      ST_DONE:               w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept     = (r_state == ST_IDLE) && step_i;
    w_issue      = (r_state == ST_SCAN) && w_found && w_room;
    w_load_count = (r_state == ST_SCAN) && !w_found;
    busy_o       = (r_state != ST_IDLE);
    done_o       = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_step_cnt <= '0;
      r_count    <= '0;
      r_insert   <= 1'b0;
      r_data     <= '0;
      r_occ      <= '0;
    end else begin
      if (w_accept) begin
        r_mask     <= spikes_i;
        r_step_cnt <= '0;
      end else if (w_issue) begin
        // x & (x-1) drops exactly the lowest set bit, i.e. the one just sent.
        r_mask     <= r_mask & (r_mask - NUM_NEURONS'(1));
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
      if (w_issue) begin
        r_data <= w_idx;
      end
      if (w_load_count) begin
        r_count <= r_step_cnt;
      end
      r_insert <= w_issue;
      r_occ    <= w_occ_next;
    end
  end

  assign insert_o = r_insert;
  assign data_o   = r_data;
  assign count_o  = r_count;

`ifdef SPIKE_ENCODER_STATS_EN
  logic [31:0] r_stat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= '0;
    end else if (r_insert && (r_stat != 32'hFFFF_FFFF)) begin
      r_stat <= r_stat + 32'd1;
    end
  end

  assign stat_total_o = r_stat;
`else
  assign stat_total_o = '0;
`endif

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Upstream producer for the spike event queue. Once per timestep it samples the layer's neuron fire vector and converts every set bit into an 8-bit neuron index, written into the queue one per cycle in ascending index order. It mirrors queue occupancy from the consumer's read strobes and holds off inserts rather than letting the queue overwrite unread entries.

## Interface
- NUM_NEURONS, 256, width of the fire vector; must be ≤ 256 so indices fit 8 bits
- QUEUE_DEPTH, 1024, capacity of the downstream queue in entries
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- step_i  in  1  start-of-timestep strobe; sampled only in IDLE
- spikes_i  in  NUM_NEURONS  fire flags, latched on an accepted step_i
- queue_read_i  in  1  copy of the read strobe driven into the queue
- insert_o  out  1  queue insert strobe, registered
- data_o  out  8  neuron index for the queue, registered; valid while insert_o=1
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse at the end of a step
- count_o  out  clog2(NUM_NEURONS+1)  spikes emitted in the last completed step
- stat_total_o  out  32  lifetime spike total (see Configuration)

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On step_i, latch spikes_i into the pending mask, clear the step counter, and go to SCAN.
  - Otherwise hold.
- SCAN, each cycle:
  - If the mask is nonzero and there is room, take the lowest set bit i. Register insert_o=1 and data_o=i, clear bit i, and increment the step counter.
  - If the mask is nonzero and there is no room, insert_o=0 and the mask is unchanged (stall).
  - If the mask is zero, insert_o=0, load count_o from the step counter, and go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Occupancy counter, width clog2(QUEUE_DEPTH)+1:
  - occ_next = occ + insert_o − (queue_read_i && occ≠0).
  - A read while occ=0 has no effect.
  - A simultaneous insert and read leaves occ unchanged.
- Room: the block may issue when occ_next < QUEUE_DEPTH.
- step_i while busy_o=1 is ignored; no queuing and no error flag.
- data_o holds its last value when insert_o=0.

## Timing
- Reset values: insert_o=0, data_o=0, busy_o=0, done_o=0, count_o=0, stat_total_o=0, occ=0, mask=0, state IDLE.
- step_i is sampled at edge E0.
- With k spikes and no stall:
  - insert_o is high for k consecutive cycles following edges E1..Ek.
  - done_o is high in the cycle after the last insert.
- k=0: done_o is high the cycle after E1, with no inserts.
- A stall inserts bubbles in insert_o. Index order stays strictly ascending.
- At occ = QUEUE_DEPTH−1 with no read, one insert is allowed. The next one waits until queue_read_i is seen.
- rst during SCAN takes effect at the next edge: the pending mask is discarded and occ is cleared. The queue shares this rst, so the two stay consistent.
- done_o and busy_o are asserted in the same cycle; busy_o drops the cycle after done_o.
- A new step_i is accepted no earlier than the cycle after done_o.

## Configuration
- SPIKE_ENCODER_STATS_EN defined:
  - stat_total_o is a 32-bit counter incremented on every insert.
  - It saturates at 0xFFFFFFFF and is cleared only by rst.
- SPIKE_ENCODER_STATS_EN undefined:
  - stat_total_o is tied to 0.
  - No counter logic is synthesised.

## Structure
- Shared package snn_pkg holds:
  - NEURON_ID_W = 8
  - QUEUE_DEPTH_DEFAULT = 1024
  - the FSM state enum spike_enc_state_t
- Sub-module prio_enc_lsb: combinational lowest-set-bit encoder, NUM_NEURONS wide. Outputs are the index and a found flag.
- Top level: FSM, mask register, occupancy counter, step counter, optional stats counter.

## Test plan
- Reset mid-scan with spikes_i bit 10 and bit 200 set: assert rst after the first insert -> bit 200 is never inserted, all outputs return to reset values, and occ=0.
- spikes_i = bits {0,3,255}, step_i -> insert_o high 3 consecutive cycles with data_o 0x00, 0x03, 0xFF; done_o the next cycle; count_o=3.
- spikes_i all-zero, step_i -> no insert_o; done_o two cycles after step_i is sampled; count_o=0.
- QUEUE_DEPTH=4, spikes_i bits 0–5, no reads -> exactly 4 inserts (0–3), busy_o stays high. Then one queue_read_i pulse -> index 4 inserted. Another pulse -> index 5, then done_o, count_o=6.
- step_i pulsed again during SCAN with a different vector -> ignored; only the first vector's indices appear.
- SPIKE_ENCODER_STATS_EN defined, two steps of 3 and 5 spikes -> stat_total_o=8. With the macro undefined -> stat_total_o stays 0.
